// File: rtl/calc_alu.sv
// Multi-operation arithmetic unit (add, sub, iterative mul/div) for the UART calculator.
// Define CALC_ALU_DIV_EN to compile in the restoring divider; otherwise DIV reports an error.
module calc_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 parser_done,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 calc_done,
    output logic [2*WIDTH-1:0]   calc_res,
    output logic                 calc_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic                 pd_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   acc_r;

    logic                 start_s;
    logic                 last_s;
    logic                 fin_s;
    logic                 err_s;
    logic [2*WIDTH-1:0]   res_s;
    logic [2*WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH:0]       mul_sum_s;
`ifdef CALC_ALU_DIV_EN
    logic [WIDTH:0]       div_trial_s;
    logic                 div_ge_s;
    logic [WIDTH-1:0]     div_rem_s;
`endif

    assign start_s = parser_done & ~pd_r & ~busy;
    assign last_s  = (cnt_r == CW'(WIDTH - 1));

    // One iteration step of the selected operation and the completion result.
    // acc_r holds {high, low}: for MUL the low half is the shrinking multiplier,
    // for DIV it is {remainder, dividend/quotient} as bits shift through.
    always_comb begin
        fin_s     = 1'b0;
        err_s     = 1'b0;
        res_s     = {(2*WIDTH){1'b0}};
        acc_nxt_s = acc_r;
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
`ifdef CALC_ALU_DIV_EN
        div_trial_s = acc_r[2*WIDTH-1:WIDTH-1];
        div_ge_s    = (div_trial_s >= {1'b0, b_r});
        if (div_ge_s) begin
            div_rem_s = WIDTH'(div_trial_s - {1'b0, b_r});
        end else begin
            div_rem_s = div_trial_s[WIDTH-1:0];
        end
`endif
        case (op_r)
            2'd0: begin
                fin_s = 1'b1;
                res_s = {{(WIDTH-1){1'b0}}, ({1'b0, a_r} + {1'b0, b_r})};
            end
            2'd1: begin
                fin_s = 1'b1;
                res_s = {{WIDTH{1'b0}}, a_r} - {{WIDTH{1'b0}}, b_r};
            end
            2'd2: begin
                acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
                if (last_s) begin
                    fin_s = 1'b1;
                    res_s = acc_nxt_s;
                end else begin
                    fin_s = 1'b0;
                end
            end
            2'd3: begin
`ifdef CALC_ALU_DIV_EN
                if (b_r == {WIDTH{1'b0}}) begin
                    fin_s = 1'b1;
                    err_s = 1'b1;
                    res_s = {(2*WIDTH){1'b1}};
                end else begin
                    acc_nxt_s = {div_rem_s, acc_r[WIDTH-2:0], div_ge_s};
                    if (last_s) begin
                        fin_s = 1'b1;
                        res_s = acc_nxt_s;
                    end else begin
                        fin_s = 1'b0;
                    end
                end
`else
                fin_s = 1'b1;
                err_s = 1'b1;
                res_s = {(2*WIDTH){1'b1}};
`endif
            end
            default: begin
                fin_s = 1'b1;
                err_s = 1'b1;
                res_s = {(2*WIDTH){1'b1}};
            end
        endcase
    end

    // Control FSM, operand latches and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            pd_r      <= 1'b0;
            op_r      <= 2'd0;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            busy      <= 1'b0;
            calc_done <= 1'b0;
            calc_res  <= {(2*WIDTH){1'b0}};
            calc_err  <= 1'b0;
        end else begin
            pd_r      <= parser_done;
            calc_done <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        op_r    <= op;
                        a_r     <= src1;
                        b_r     <= src2;
                        cnt_r   <= {CW{1'b0}};
                        acc_r   <= (op == 2'd3) ? {{WIDTH{1'b0}}, src1}
                                                : {{WIDTH{1'b0}}, src2};
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (fin_s) begin
                        calc_res  <= res_s;
                        calc_err  <= err_s;
                        calc_done <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
